// File: rtl/apb_slave_mem_if.sv
//==============================================================================
// Module      : apb_slave_mem_if
// Description : APB3 bus bundle between an initiator and the memory completer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface apb_slave_mem_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

`default_nettype wire

// File: rtl/apb_slave_mem.sv
//==============================================================================
// Module      : apb_slave_mem
// Description : APB3 completer backed by a word memory, with programmable wait
//               states, PSLVERR on bad addresses and protocol checking.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_slave_mem #(
    parameter int AWIDTH    = 10,
    parameter int MEM_WORDS = 1024,
    parameter int TPD       = 1
) (
    input  wire logic         PCLK,
    input  wire logic         PRESET,
    apb_slave_mem_if.slave    apb,
    input  wire logic [3:0]   WAIT_CFG,
    output logic      [15:0]  ACC_COUNT,
    output logic              PROT_ERR
);

    if (MEM_WORDS < 1 || MEM_WORDS > (1 << AWIDTH) || TPD < 0) begin : g_bad_params
        $error("apb_slave_mem: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] prdata_q, prdata_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic        prot_err_q, prot_err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic        mem_we;

    logic [31:0] mem_q [MEM_WORDS];

    logic [AWIDTH-1:0] setup_idx;
    logic [AWIDTH-1:0] held_idx;
    logic              setup_err;
    logic              held_mismatch;

    assign setup_idx     = apb.PADDR[AWIDTH+1:2];
    assign held_idx      = addr_q[AWIDTH+1:2];
    assign setup_err     = (apb.PADDR[1:0] != 2'b00) || (32'(setup_idx) >= 32'(MEM_WORDS));
    assign held_mismatch = (apb.PADDR != addr_q) || (apb.PWRITE != write_q) ||
                           (apb.PWDATA != wdata_q);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        write_d    = write_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        pready_d   = pready_q;
        prdata_d   = prdata_q;
        pslverr_d  = pslverr_q;
        prot_err_d = prot_err_q;
        acc_d      = acc_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                prdata_d  = 32'h0;
                pslverr_d = 1'b0;
                if (apb.PSEL && !apb.PENABLE) begin
                    state_d = ACCESS;
                    addr_d  = apb.PADDR;
                    wdata_d = apb.PWDATA;
                    write_d = apb.PWRITE;
                    err_d   = setup_err;
                    cnt_d   = WAIT_CFG;
                    rdata_d = (!apb.PWRITE && !setup_err) ? mem_q[setup_idx] : 32'h0;
                    if (WAIT_CFG == 4'd0) begin
                        pready_d  = 1'b1;
                        prdata_d  = rdata_d;
                        pslverr_d = setup_err;
                    end
                end else if (apb.PSEL && apb.PENABLE) begin
                    prot_err_d = 1'b1;
                end
            end

            ACCESS: begin
                if (!apb.PSEL || !apb.PENABLE || held_mismatch) begin
                    // Abort: nothing commits, nothing counts.
                    state_d    = IDLE;
                    prot_err_d = 1'b1;
                    cnt_d      = 4'd0;
                    pready_d   = 1'b0;
                    prdata_d   = 32'h0;
                    pslverr_d  = 1'b0;
                end else if (pready_q) begin
                    state_d   = IDLE;
                    mem_we    = write_q && !err_q;
                    acc_d     = (acc_q == 16'hFFFF) ? acc_q : acc_q + 16'd1;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b0;
                    prdata_d  = 32'h0;
                    pslverr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        prdata_d  = rdata_q;
                        pslverr_d = err_q;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 4'd0;
            pready_q   <= 1'b0;
            prdata_q   <= 32'h0;
            pslverr_q  <= 1'b0;
            prot_err_q <= 1'b0;
            acc_q      <= 16'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            write_q    <= write_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            prot_err_q <= prot_err_d;
            acc_q      <= acc_d;
        end
    end

    // Memory contents survive reset; only the commit is suppressed by it.
    always_ff @(posedge PCLK) begin
        if (!PRESET && mem_we) begin
            mem_q[held_idx] <= wdata_q;
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign ACC_COUNT   = acc_q;
    assign PROT_ERR    = prot_err_q;

endmodule

`default_nettype wire
